inst_rom_loader: RTL
====================

# inst_rom_loader

Instruction-memory responder for the AHU_LA2023 core's fetch port. It answers `rom_ce`/`inst_addr` fetches with 32-bit instruction words. It also owns the load path: a byte-stream loader writes the program into memory while the core is held in reset, then releases the core to run. It sits at the top level beside the core, driving the core's `inst_i` and reset.

## Interface
Parameters:
- `ADDR_W`, default 10: word-address width. Depth is 2^ADDR_W words.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge
- `rst`  in  1  reset; asynchronous, active-low
- `rom_ce_i`  in  1  fetch enable from core
- `inst_addr_i`  in  32  byte fetch address from core; word index is `inst_addr_i[ADDR_W+1:2]`
- `inst_o`  out  32  fetched instruction, combinational
- `ld_valid_i`  in  1  loader byte valid
- `ld_byte_i`  in  8  loader byte
- `ld_last_i`  in  1  qualifies the final byte of the image
- `ld_ready_o`  out  1  loader may present a byte
- `ld_start_i`  in  1  single-cycle pulse that restarts loading
- `core_rst_o`  out  1  active-low reset to the core, registered
- `ld_words_o`  out  ADDR_W+1  words written in the current or last load
- `ld_err_o`  out  1  sticky load error
- `fetch_err_o`  out  1  sticky misaligned-fetch flag; see Configuration

## Operation
- FSM has three states: LOAD, RELEASE, RUN. Reset enters LOAD.
- Reset values: `core_rst_o`=0, `ld_ready_o`=1, `ld_words_o`=0, `ld_err_o`=0, `fetch_err_o`=0. Byte counter `bcnt`=0, write pointer `wptr`=0. Memory contents are not reset.
- **LOAD state**
  - `ld_ready_o`=1 and `core_rst_o`=0.
  - A byte is accepted when `ld_valid_i` and `ld_ready_o` are both high.
  - Bytes are assembled little-endian: byte 0 goes to [7:0], byte 3 to [31:24].
  - When the 4th byte is accepted, the word is written to `mem[wptr]`, then `wptr`++, `ld_words_o`++, and `bcnt` returns to 0.
- **Last byte** (`ld_last_i` on an accepted byte):
  - The current word is written, with any missing upper bytes zero-filled.
  - If `bcnt` was not 3, `ld_err_o` is set.
  - The FSM moves to RELEASE.
- **Overflow**: a byte accepted while `wptr`==2^ADDR_W is dropped with no write. `ld_err_o` is set and the byte is still acknowledged. `ld_last_i` on such a byte still moves the FSM to RELEASE.
- **RELEASE state**: lasts exactly one cycle with `ld_ready_o`=0, then moves to RUN.
- **RUN state**: `core_rst_o`=1 and `ld_ready_o`=0; `ld_valid_i` is ignored.
- **Fetch**: `inst_o` = `mem[inst_addr_i[ADDR_W+1:2]]` when `rom_ce_i`=1 and the state is RUN; otherwise `inst_o`=32'h0. Address bits above ADDR_W+1 are ignored, so addresses alias.
- **`ld_start_i`**, in any state, takes effect on the next edge:
  - State becomes LOAD; `core_rst_o` goes to 0.
  - `wptr`, `bcnt`, `ld_words_o` and `ld_err_o` are cleared. `fetch_err_o` is also cleared.
  - A byte presented in the same cycle as `ld_start_i` is discarded.
  - `ld_start_i` has priority over byte acceptance and `ld_last_i`.
- Asynchronous reset mid-load abandons the partial word. Words already written remain in memory.

## Timing
- Fetch latency is 0 cycles: `inst_o` is combinational from `inst_addr_i` and `rom_ce_i`. This matches the core's same-cycle capture of `inst_i` into its IF/ID register.
- A word written on edge k is readable immediately after edge k.
- Release sequence:
  - Last byte accepted on edge k → RELEASE after edge k.
  - RUN and `core_rst_o`=1 after edge k+1.
  - The core sees its first unreset cycle from k+1.
- `ld_start_i` sampled on edge j → `core_rst_o`=0 and `ld_ready_o`=1 after edge j.
- Maximum load throughput is one byte per cycle with `ld_valid_i` held high.
- `core_rst_o` comes directly from a flop, with no combinational path from inputs.

## Configuration
Macro `INST_ROM_ALIGN_CHK_EN`:
- **Defined**: a RUN-state fetch with `rom_ce_i`=1 and `inst_addr_i[1:0]`≠0 returns `inst_o`=32'h0. It also sets `fetch_err_o`, which stays set until `ld_start_i` or reset.
- **Undefined**: `inst_addr_i[1:0]` are ignored, and `fetch_err_o` is tied to 0.

## Test plan
All scenarios use `ADDR_W`=4 (16 words).
- Reset, then stream bytes 13,00,00,00, 37,00,00,00 (hex) with `ld_last_i` on the 8th → `ld_words_o`=2 and `ld_err_o`=0. `core_rst_o` rises 2 edges after the last byte. Fetch at addr 0x4 returns 32'h00000037.
- Stream 3 bytes AA,BB,CC with `ld_last_i` on CC → `mem[0]`=32'h00CCBBAA and `ld_err_o`=1; the FSM still reaches RUN.
- Stream 68 bytes → the 65th to 68th are dropped, `ld_words_o`=16, `ld_err_o`=1. Fetch at addr 0x40 aliases to `mem[0]`.
- In RUN, pulse `ld_start_i` with `ld_valid_i`=1 in the same cycle → that byte is not written. `core_rst_o`=0 and `ld_words_o`=0 after the edge.
- In RUN, fetch with `rom_ce_i`=0 → `inst_o`=0. During LOAD with `rom_ce_i`=1 → `inst_o`=0.
- With `INST_ROM_ALIGN_CHK_EN` defined, fetch addr 0x6 in RUN → `inst_o`=0 and `fetch_err_o`=1 until `ld_start_i`. With the macro undefined, the same fetch returns `mem[1]`.

Source files
------------

// File: rtl/inst_rom_loader.sv
// Instruction memory for the core's fetch port, filled by a byte-stream loader while the core is held in reset.
// Optional misaligned-fetch checking is enabled by defining INST_ROM_ALIGN_CHK_EN.
module inst_rom_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       inst_addr_i,
  output logic [31:0]       inst_o,
  input  logic              ld_valid_i,
  input  logic [7:0]        ld_byte_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  input  logic              ld_start_i,
  output logic              core_rst_o,
  output logic [ADDR_W:0]   ld_words_o,
  output logic              ld_err_o,
  output logic              fetch_err_o
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_LOAD, S_RELEASE, S_RUN} state_t;

  state_t            r_state;
  logic [31:0]       r_mem [DEPTH];
  logic [23:0]       r_word;
  logic [1:0]        r_bcnt;
  logic [ADDR_W:0]   r_wptr;
  logic [ADDR_W:0]   r_ld_words;
  logic              r_ld_err;
  logic              r_fetch_err;
  logic              r_core_rst;
  logic              r_ld_ready;

  logic              w_accept;
  logic              w_full;
  logic              w_wr;
  logic [31:0]       w_wdata;
  logic [ADDR_W-1:0] w_ridx;
  logic              w_misalign;
  logic              w_fetch_ok;
  logic              w_unused;

  // ld_start_i wins over any byte presented in the same cycle.
  assign w_accept = (r_state == S_LOAD) && ld_valid_i && !ld_start_i;
  assign w_full   = r_wptr[ADDR_W];
  assign w_wr     = w_accept && !w_full && (ld_last_i || (r_bcnt == 2'd3));

  // Little-endian assembly; bytes not yet received are zero-filled.
  always_comb begin
    w_wdata = 32'h0;
    case (r_bcnt)
      2'd0:    w_wdata = {24'h0, ld_byte_i};
      2'd1:    w_wdata = {16'h0, ld_byte_i, r_word[7:0]};
      2'd2:    w_wdata = {8'h0, ld_byte_i, r_word[15:0]};
      default: w_wdata = {ld_byte_i, r_word};
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr[ADDR_W-1:0]] <= w_wdata;
    end
  end

  assign w_ridx = inst_addr_i[ADDR_W+1:2];

`ifdef INST_ROM_ALIGN_CHK_EN
  assign w_misalign = (inst_addr_i[1:0] != 2'b00);
  assign w_unused   = ^inst_addr_i[31:ADDR_W+2];
`else
  assign w_misalign = 1'b0;
  assign w_unused   = ^{inst_addr_i[31:ADDR_W+2], inst_addr_i[1:0]};
`endif

  assign w_fetch_ok = rom_ce_i && (r_state == S_RUN) && !w_misalign;
  assign inst_o     = w_fetch_ok ? r_mem[w_ridx] : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_LOAD;
      r_word      <= 24'h0;
      r_bcnt      <= 2'd0;
      r_wptr      <= '0;
      r_ld_words  <= '0;
      r_ld_err    <= 1'b0;
      r_fetch_err <= 1'b0;
      r_core_rst  <= 1'b0;
      r_ld_ready  <= 1'b1;
    end else if (ld_start_i) begin
      r_state     <= S_LOAD;
      r_bcnt      <= 2'd0;
      r_wptr      <= '0;
      r_ld_words  <= '0;
      r_ld_err    <= 1'b0;
      r_fetch_err <= 1'b0;
      r_core_rst  <= 1'b0;
      r_ld_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (ld_valid_i) begin
            if (w_full) begin
              r_ld_err <= 1'b1;
            end else if (w_wr) begin
              r_wptr     <= r_wptr + 1'b1;
              r_ld_words <= r_ld_words + 1'b1;
              r_bcnt     <= 2'd0;
              if (ld_last_i && (r_bcnt != 2'd3)) begin
                r_ld_err <= 1'b1;
              end
            end else begin
              r_bcnt <= r_bcnt + 2'd1;
              case (r_bcnt)
                2'd0:    r_word[7:0]   <= ld_byte_i;
                2'd1:    r_word[15:8]  <= ld_byte_i;
                default: r_word[23:16] <= ld_byte_i;
              endcase
            end
            if (ld_last_i) begin
              r_state    <= S_RELEASE;
              r_ld_ready <= 1'b0;
              r_bcnt     <= 2'd0;
            end
          end
        end
        S_RELEASE: begin
          r_state    <= S_RUN;
          r_core_rst <= 1'b1;
        end
        S_RUN: begin
          if (rom_ce_i && w_misalign) begin
            r_fetch_err <= 1'b1;
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign ld_ready_o  = r_ld_ready;
  assign core_rst_o  = r_core_rst;
  assign ld_words_o  = r_ld_words;
  assign ld_err_o    = r_ld_err;
  assign fetch_err_o = r_fetch_err;

endmodule
